// File: rtl/cluster_cg_pkg.sv
// Shared types and next-state logic for the cluster clock-gating controller.
package cluster_cg_pkg;

  // Widest idle counter the shared next-state function can handle.
  localparam int unsigned CntMaxW = 32;

  typedef enum logic [1:0] {
    CgOn    = 2'd0,
    CgCount = 2'd1,
    CgOff   = 2'd2,
    CgWake  = 2'd3
  } cg_state_e;

  typedef struct packed {
    cg_state_e            state;
    logic [CntMaxW-1:0]   cnt;
  } cg_next_t;

  // Next state and idle count for one channel.
  function automatic cg_next_t cg_next_state(input cg_state_e          state,
                                             input logic [CntMaxW-1:0] cnt,
                                             input logic [CntMaxW-1:0] thresh,
                                             input logic               hold);
    cg_next_t nxt;
    logic     stay_on;
    // A zero threshold disables auto-gating and behaves like a permanent hold.
    stay_on   = hold | (thresh == '0);
    nxt.state = state;
    nxt.cnt   = '0;
    unique case (state)
      CgOn: begin
        if (!stay_on) begin
          nxt.state = CgCount;
          nxt.cnt   = CntMaxW'(1);
        end
      end
      CgCount: begin
        if (stay_on) begin
          nxt.state = CgOn;
        end else if (cnt >= thresh) begin
          // >= so a threshold lowered below the running count gates at once.
          nxt.state = CgOff;
        end else begin
          nxt.cnt = cnt + CntMaxW'(1);
        end
      end
      CgOff: begin
        if (stay_on) begin
          nxt.state = CgWake;
        end
      end
      CgWake: begin
        // One settle cycle so the gate latch is open before acknowledging.
        nxt.state = CgOn;
      end
      default: begin
        nxt.state = CgOn;
      end
    endcase
    return nxt;
  endfunction

  // Clock enable applied to the gate cell in a given state.
  function automatic logic cg_clk_en(input cg_state_e state);
    return state != CgOff;
  endfunction

  // States in which a pending wake request may be acknowledged.
  function automatic logic cg_ack_ok(input cg_state_e state);
    return (state == CgOn) || (state == CgCount);
  endfunction

endpackage

// File: rtl/cluster_clock_gating_ch.sv
// One gated-clock channel: idle FSM, idle counter, wake acknowledge and gate cell.
module cluster_clock_gating_ch
  import cluster_cg_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W = 8,
  parameter bit          RESET_ON   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic                  busy_i,
  input  logic                  force_on_i,
  input  logic                  wake_req_i,
  output logic                  wake_ack_o,
  output logic                  clk_en_o,
  output logic                  clk_o
);

  cg_state_e             state_q, state_d;
  logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  clk_en_q, clk_en_d;
  logic                  hold;
  cg_next_t              nxt;
  logic                  unused_nxt_cnt;

  assign hold = busy_i | force_on_i | wake_req_i;

  // Next-state decode; the counter never exceeds the threshold, so truncation is safe.
  always_comb begin
    nxt      = cg_next_state(state_q, CntMaxW'(cnt_q), CntMaxW'(idle_thresh_i), hold);
    state_d  = nxt.state;
    cnt_d    = nxt.cnt[IDLE_CNT_W-1:0];
    clk_en_d = cg_clk_en(nxt.state);
    ack_d    = wake_req_i & cg_ack_ok(nxt.state);
  end

  assign unused_nxt_cnt = ^nxt.cnt;

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if (RESET_ON) begin
        state_q <= CgOn;
      end else begin
        state_q <= CgOff;
      end
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      clk_en_q <= RESET_ON;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign wake_ack_o = ack_q;
  assign clk_en_o   = clk_en_q;

  pulp_clock_gating u_cg (
    .clk_i     (clk_i),
    .en_i      (clk_en_q),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );

endmodule

// File: rtl/pulp_clock_gating.sv
// Latch-based glitch-free clock gate; the latch is transparent while the clock is low.
module pulp_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic clk_en;

  // Capture the enable during the low phase so it cannot change under a high clock.
  always_latch begin
    if (!clk_i) begin
      clk_en = en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/cluster_clock_gating_ctrl.sv
// Multi-channel idle-based clock-gating controller for the cluster.
module cluster_clock_gating_ctrl #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IDLE_CNT_W = 8,
  parameter bit          RESET_ON   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic [NUM_CH-1:0]     busy_i,
  input  logic [NUM_CH-1:0]     force_on_i,
  input  logic [NUM_CH-1:0]     wake_req_i,
  output logic [NUM_CH-1:0]     wake_ack_o,
  output logic [NUM_CH-1:0]     clk_en_o,
  output logic [NUM_CH-1:0]     clk_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cluster_clock_gating_ch #(
      .IDLE_CNT_W (IDLE_CNT_W),
      .RESET_ON   (RESET_ON)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .test_en_i     (test_en_i),
      .idle_thresh_i (idle_thresh_i),
      .busy_i        (busy_i[i]),
      .force_on_i    (force_on_i[i]),
      .wake_req_i    (wake_req_i[i]),
      .wake_ack_o    (wake_ack_o[i]),
      .clk_en_o      (clk_en_o[i]),
      .clk_o         (clk_o[i])
    );
  end

endmodule

// File: tb/tb_cluster_clock_gating_ctrl.sv
// Directed bench for cluster_clock_gating_ctrl: cycle table plus multi-cycle corner sequences.
module tb_cluster_clock_gating_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       test_en = 1'b0;
  logic [7:0] thresh = 8'd3;
  logic [3:0] busy = 4'hF;
  logic [3:0] force_on = 4'h0;
  logic [3:0] req = 4'h0;
  logic [3:0] ack_a, en_a, gclk_a;
  logic [3:0] ack_b, en_b, gclk_b;

  int checks = 0;
  int errors = 0;
  int edges0 = 0;

  always #5 clk = ~clk;

  always @(posedge gclk_a[0]) edges0++;

  cluster_clock_gating_ctrl #(
    .NUM_CH     (4),
    .IDLE_CNT_W (8),
    .RESET_ON   (1'b1)
  ) dut_a (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_en_i     (test_en),
    .idle_thresh_i (thresh),
    .busy_i        (busy),
    .force_on_i    (force_on),
    .wake_req_i    (req),
    .wake_ack_o    (ack_a),
    .clk_en_o      (en_a),
    .clk_o         (gclk_a)
  );

  cluster_clock_gating_ctrl #(
    .NUM_CH     (4),
    .IDLE_CNT_W (8),
    .RESET_ON   (1'b0)
  ) dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .test_en_i     (test_en),
    .idle_thresh_i (thresh),
    .busy_i        (busy),
    .force_on_i    (force_on),
    .wake_req_i    (req),
    .wake_ack_o    (ack_b),
    .clk_en_o      (en_b),
    .clk_o         (gclk_b)
  );

  typedef struct {
    logic [3:0] busy;
    logic [3:0] req;
    logic [3:0] exp_en;
    logic [3:0] exp_ack;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    busy     = 4'hF;
    force_on = 4'h0;
    req      = 4'h0;
    thresh   = 8'd3;
    test_en  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_off;

    // Thresh 3, ch2 forced on throughout; rows are one clock edge each.
    tbl[0]  = '{4'b1000, 4'b0000, 4'b1111, 4'b0000};
    tbl[1]  = '{4'b1000, 4'b0000, 4'b1111, 4'b0000};
    tbl[2]  = '{4'b1000, 4'b0000, 4'b1111, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b0000, 4'b1100, 4'b0000};
    tbl[4]  = '{4'b1000, 4'b0000, 4'b1100, 4'b0000};
    tbl[5]  = '{4'b1000, 4'b0010, 4'b1110, 4'b0000};
    tbl[6]  = '{4'b1000, 4'b0010, 4'b1110, 4'b0010};
    tbl[7]  = '{4'b1000, 4'b0010, 4'b1110, 4'b0010};
    tbl[8]  = '{4'b1000, 4'b0000, 4'b1110, 4'b0000};
    tbl[9]  = '{4'b1000, 4'b0000, 4'b1110, 4'b0000};
    tbl[10] = '{4'b1000, 4'b0000, 4'b1110, 4'b0000};
    tbl[11] = '{4'b1000, 4'b0000, 4'b1100, 4'b0000};
    tbl[12] = '{4'b1001, 4'b0000, 4'b1101, 4'b0000};
    tbl[13] = '{4'b0000, 4'b1000, 4'b1101, 4'b1000};
    tbl[14] = '{4'b0000, 4'b1000, 4'b1101, 4'b1000};
    tbl[15] = '{4'b0000, 4'b1000, 4'b1101, 4'b1000};
    tbl[16] = '{4'b0000, 4'b1000, 4'b1101, 4'b1000};
    tbl[17] = '{4'b0000, 4'b1000, 4'b1100, 4'b1000};
    tbl[18] = '{4'b0000, 4'b0000, 4'b1100, 4'b0000};

    // Reset values for both reset polarities of the channel enable.
    do_reset();
    check("reset_en_on", en_a, 4'hF);
    check("reset_ack_on", ack_a, 4'h0);
    check("reset_en_off", en_b, 4'h0);
    check("reset_ack_off", ack_b, 4'h0);

    // Table: idle gating, wake handshake, force-on, simultaneous channel events.
    force_on = 4'b0100;
    thresh   = 8'd3;
    for (int i = 0; i < 19; i++) begin
      busy = tbl[i].busy;
      req  = tbl[i].req;
      tick();
      check($sformatf("tbl%0d_en", i), en_a, tbl[i].exp_en);
      check($sformatf("tbl%0d_ack", i), ack_a, tbl[i].exp_ack);
    end

    // Asynchronous reset mid-count with an acknowledge outstanding.
    do_reset();
    busy = 4'b0110;
    req  = 4'b1000;
    tick();
    tick();
    check("pre_rst_ack", ack_a, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en_on", en_a, 4'hF);
    check("async_rst_ack_on", ack_a, 4'h0);
    check("async_rst_en_off", en_b, 4'h0);
    check("async_rst_ack_off", ack_b, 4'h0);
    #2;
    req   = 4'h0;
    busy  = 4'h0;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_e3_en", en_a, 4'hF);
    check("post_rst_off_b", en_b, 4'h0);
    tick();
    check("post_rst_e4_en", en_a, 4'h0);

    // Busy pulse at e3 restarts the idle count.
    do_reset();
    busy = 4'b1110;
    tick();
    tick();
    busy = 4'b1111;
    tick();
    check("pulse_e3_en0", en_a[0], 1'b1);
    busy = 4'b1110;
    tick();
    tick();
    tick();
    check("pulse_e6_en0", en_a[0], 1'b1);
    tick();
    check("pulse_e7_en0", en_a[0], 1'b0);

    // Gated clock stops while off, and test enable forces it to run.
    edges0 = 0;
    repeat (3) tick();
    check("gclk0_stopped", edges0, 0);
    test_en = 1'b1;
    edges0  = 0;
    repeat (3) tick();
    check("gclk0_test_runs", (edges0 >= 2), 1'b1);
    check("test_en_en0", en_a[0], 1'b0);
    test_en = 1'b0;

    // Zero threshold while off wakes the channel and keeps it on.
    thresh = 8'd0;
    tick();
    check("t0_wake_en0", en_a[0], 1'b1);
    check("t0_wake_ack0", ack_a[0], 1'b0);
    tick();
    tick();
    check("t0_stay_en0", en_a[0], 1'b1);

    // Threshold lowered below the running count gates at the next edge.
    do_reset();
    thresh = 8'd10;
    busy   = 4'b1110;
    repeat (5) tick();
    check("tlow_cnt5_en0", en_a[0], 1'b1);
    thresh = 8'd2;
    tick();
    check("tlow_off_en0", en_a[0], 1'b0);

    // Maximum threshold: no wrap, gate after exactly 255 idle cycles.
    do_reset();
    thresh    = 8'd255;
    busy      = 4'b1110;
    first_off = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (first_off == 0 && en_a[0] == 1'b0) first_off = i;
    end
    check("tmax_first_off_edge", first_off, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
